// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_e;
  typedef enum logic {GRANT_I, GRANT_D} grant_e;

  localparam int S_LINE   = 256;
  localparam int S_OFFSET = 5;

endpackage

// File: rtl/cache_arbiter_arb_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
module arb_pick
  import cache_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_e last_grant,
  output grant_e o_grant,
  output logic   o_valid
);

  // On a tie the client that was not granted last wins.
  always_comb begin
    o_valid = i_req | d_req;
    o_grant = GRANT_I;
    if (i_req && d_req) begin
      o_grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      o_grant = GRANT_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one physical memory port.
// Define CACHE_ARB_RR_EN for round-robin ties; otherwise the D-cache always wins ties.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = S_LINE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_addr,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_addr,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  grant_e     w_pick_grant;
  grant_e     w_last_grant;
  logic       w_pick_valid;
  logic       w_d_req;
  logic       w_unused;

  assign w_d_req      = d_pmem_read | d_pmem_write;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign w_unused     = ^{i_pmem_addr[s_offset-1:0], d_pmem_addr[s_offset-1:0]};

`ifdef CACHE_ARB_RR_EN
  grant_e r_last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_I;
    end else if (r_state == IDLE && w_pick_valid) begin
      r_last_grant <= w_pick_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  // Pinning last_grant to I makes every tie resolve to the D-cache.
  assign w_last_grant = GRANT_I;
`endif

  arb_pick u_pick (
    .i_req      (i_pmem_read),
    .d_req      (w_d_req),
    .last_grant (w_last_grant),
    .o_grant    (w_pick_grant),
    .o_valid    (w_pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The grant is held in the state itself, so pmem_addr cannot move mid-transaction.
  always_comb begin
    w_state_nxt = r_state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = '0;
    pmem_wdata  = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = (w_pick_grant == GRANT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = {i_pmem_addr[31:s_offset], {s_offset{1'b0}}};
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        // A simultaneous read and write is illegal; the write takes the bus.
        pmem_write = d_pmem_write;
        pmem_read  = d_pmem_read & ~d_pmem_write;
        pmem_wdata = d_pmem_wdata;
        pmem_addr  = {d_pmem_addr[31:s_offset], {s_offset{1'b0}}};
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  a_d_rw_exclusive: assert property (
    @(posedge clk) disable iff (!reset_n) !(d_pmem_read && d_pmem_write)
  );

endmodule
